mpf_vtp_port_arbiter: RTL
=========================

# mpf_vtp_port_arbiter

Shares one VTP translation service port among `N_REQ` translation requesters, e.g. the read and write channels of several Avalon or AXI translate shims, so that they all use a single VTP TLB/page-walker port. The arbiter grants requests round-robin and records each granted requester ID in an in-order tag FIFO. It routes each in-order service response back to the requester that issued it, and throttles issue so no more than `MAX_OUTSTANDING` translations are in flight.

## Interface
- `N_REQ`, 2: number of requester ports (2..8).
- `VA_WIDTH`, 42: virtual line-address width.
- `PA_WIDTH`, 42: physical line-address width.
- `MAX_OUTSTANDING`, 16: maximum number of in-flight translations; must be a power of 2, 2..64.

- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_addr`, in, N_REQ×VA_WIDTH: per-requester virtual address.
- `req_is_ordered`, in, N_REQ: per-requester fence flag.
- `req_ready`, out, N_REQ: per-requester grant; the request transfers when valid&&ready.
- `rsp_valid`, out, N_REQ: per-requester response strobe (one cycle; no backpressure).
- `rsp_addr`, out, PA_WIDTH: translated address, shared by all requesters and qualified by `rsp_valid`.
- `rsp_error`, out, 1: translation-failure flag, shared by all requesters and qualified by `rsp_valid`.
- `svc_req_valid`, out, 1: request to the VTP service.
- `svc_req_ready`, in, 1: VTP service accepts the request.
- `svc_req_addr`, out, VA_WIDTH: address presented to the service.
- `svc_req_is_ordered`, out, 1: fence flag presented to the service.
- `svc_rsp_valid`, in, 1: service response strobe; responses return in request order.
- `svc_rsp_addr`, in, PA_WIDTH: translated address from the service.
- `svc_rsp_error`, in, 1: translation error from the service.
- `outstanding`, out, log2(MAX_OUTSTANDING)+1: current in-flight count.
- `err_unexpected_rsp`, out, 1: sticky flag set when a service response arrives with no tag outstanding.

## Operation
**Arbitration**
- Round-robin over requesters with `req_valid` set, starting at priority pointer `prio`.
- The winner is the first asserted requester at index `prio, prio+1, …`, wrapping modulo `N_REQ`.

**Issue path**
- `can_issue = (outstanding != MAX_OUTSTANDING) && !fence_pending`.
- `svc_req_valid = can_issue && |req_valid`.
- `svc_req_addr` and `svc_req_is_ordered` are muxed combinationally from the winner.
- `req_ready[winner] = can_issue && svc_req_ready`. All other `req_ready` bits are 0.
- On issue (`svc_req_valid && svc_req_ready`):
  - push the winner ID into the tag FIFO;
  - `prio <= (winner+1) mod N_REQ`;
  - if `req_is_ordered`, set `fence_pending`.
- `prio` holds when nothing issues.

**Fence handling**
- `fence_pending` blocks further issue until the tag FIFO drains to empty, i.e. until the fence's own response has been popped.
- `fence_pending` clears in the cycle the last tag pops.

**Response path**
- On `svc_rsp_valid`, pop the FIFO head and pulse `rsp_valid[head]` in the same cycle.
- `rsp_addr` and `rsp_error` pass through from the service.
- If `svc_rsp_valid` arrives while the FIFO is empty:
  - no `rsp_valid` bit asserts;
  - `err_unexpected_rsp <= 1`;
  - `outstanding` stays 0 (no underflow).

**Outstanding counter**
- Increments on issue, decrements on pop; simultaneous issue and pop leaves it unchanged.
- The full check uses the registered count only. A pop in the same cycle does not permit issue at full, which keeps the path free of combinational ready loops.

**Reset**
Asynchronous assertion; all of the following take their reset values immediately:
- `prio = 0`;
- FIFO pointers = 0 and `outstanding = 0`;
- `fence_pending = 0`;
- `err_unexpected_rsp = 0`;
- all `req_ready`, `rsp_valid` and `svc_req_valid` = 0.

In-flight translations are discarded. Responses that arrive after reset are flagged as unexpected.

## Timing
- Request path is zero-latency combinational: `req_valid` → `svc_req_valid` → (`svc_req_ready`) → `req_ready`.
- Response routing is zero-latency: `svc_rsp_valid` → `rsp_valid[id]`. Tag FIFO reads are from flops (registered head), not RAM with read latency.
- Throughput is one issue and one response per cycle, sustained, while `outstanding < MAX_OUTSTANDING`.
- After a fence issues at cycle t, its response at cycle r allows the next issue no earlier than r+1.
- `err_unexpected_rsp` is visible the cycle after the offending response.

## Test plan
1. **Round-robin fairness.** N_REQ=2, both requesters valid continuously, `svc_req_ready`=1, responses echoed 3 cycles later → grants alternate 0,1,0,1; each `rsp_valid[i]` follows that requester's grant order with the matching `rsp_addr`.
2. **Full throttle.** MAX_OUTSTANDING=4, service withholds responses → exactly 4 issues, then `req_ready`=0 and `outstanding`=4. One response arrives → no issue that cycle; issue resumes the next cycle.
3. **Fence.** Requester 1 issues with `req_is_ordered`=1 while 2 tags are outstanding → no issue until all 3 responses pop; requester 0's pending request issues the cycle after the third pop.
4. **Service backpressure.** `svc_req_ready`=0 for 5 cycles with requester 0 valid → `req_ready`=0, `prio` unchanged, `svc_req_addr` stable.
5. **Unexpected response.** `svc_rsp_valid` pulse with the FIFO empty → no `rsp_valid`, `err_unexpected_rsp`=1 (sticky), `outstanding`=0.
6. **Mid-flight reset.** Drop `reset_n` with 3 tags outstanding → all outputs at reset values immediately. After release, the first request is granted to requester 0 and `outstanding`=1.

Source files
------------

// File: rtl/mpf_vtp_port_arbiter.sv
// ---------------------------------------------------------------------------
// mpf_vtp_port_arbiter
//
// Lets N_REQ translation requesters share one VTP translation service port.
// Requests are granted round-robin. The ID of each granted requester is kept
// in an in-order tag FIFO, so each in-order service response goes back to the
// requester that issued it. Issue stops when MAX_OUTSTANDING translations are
// in flight. An ordered (fence) request blocks further issue until every tag,
// including the fence's own tag, has been returned.
//
// Parameters
//   N_REQ            number of requester ports (2..8)
//   VA_WIDTH         virtual line-address width
//   PA_WIDTH         physical line-address width
//   MAX_OUTSTANDING  in-flight limit, power of 2 (2..64)
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   req_valid/addr/is_ordered, req_ready
//                       per-requester request channels (addr is flattened,
//                       requester i occupies bits [i*VA_WIDTH +: VA_WIDTH])
//   rsp_valid           per-requester one-cycle response strobe
//   rsp_addr, rsp_error shared response payload, qualified by rsp_valid
//   svc_req_*           request channel to the VTP service
//   svc_rsp_*           in-order response channel from the VTP service
//   outstanding         number of translations currently in flight
//   err_unexpected_rsp  sticky: a response arrived with no tag outstanding
// ---------------------------------------------------------------------------
module mpf_vtp_port_arbiter #(
  parameter int N_REQ           = 2,
  parameter int VA_WIDTH        = 42,
  parameter int PA_WIDTH        = 42,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,

  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*VA_WIDTH-1:0]     req_addr,
  input  logic [N_REQ-1:0]              req_is_ordered,
  output logic [N_REQ-1:0]              req_ready,

  output logic [N_REQ-1:0]              rsp_valid,
  output logic [PA_WIDTH-1:0]           rsp_addr,
  output logic                          rsp_error,

  output logic                          svc_req_valid,
  input  logic                          svc_req_ready,
  output logic [VA_WIDTH-1:0]           svc_req_addr,
  output logic                          svc_req_is_ordered,

  input  logic                          svc_rsp_valid,
  input  logic [PA_WIDTH-1:0]           svc_rsp_addr,
  input  logic                          svc_rsp_error,

  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                          err_unexpected_rsp
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    FS_OPEN  = 1'b0,
    FS_FENCE = 1'b1
  } fence_state_t;

  // Registered state
  logic [ID_W-1:0]  r_prio;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ID_W-1:0]  r_tag_mem [MAX_OUTSTANDING];
  fence_state_t     r_fence_state;
  logic             r_err_unexp;

  // Combinational signals
  logic [ID_W-1:0]     w_winner;
  logic                w_any_valid;
  logic                w_can_issue;
  logic                w_issue;
  logic                w_pop;
  logic [ID_W-1:0]     w_head;
  logic [ID_W-1:0]     w_prio_next;
  logic [VA_WIDTH-1:0] w_sel_addr;
  logic                w_sel_ordered;
  fence_state_t        w_fence_next;

  // -------------------------------------------------------------------------
  // Round-robin winner: first valid requester at prio, prio+1, ... mod N_REQ.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned v_idx;
    logic        v_found;
    v_idx    = 0;
    v_found  = 1'b0;
    w_winner = r_prio;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      v_idx = 32'(r_prio) + i;
      if (v_idx >= N_REQ) begin
        v_idx = v_idx - N_REQ;
      end
      if (!v_found && req_valid[ID_W'(v_idx)]) begin
        v_found  = 1'b1;
        w_winner = ID_W'(v_idx);
      end
    end
  end

  assign w_any_valid = |req_valid;

  // Request payload mux from the winner
  always_comb begin
    w_sel_addr    = '0;
    w_sel_ordered = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_addr    = req_addr[i*VA_WIDTH +: VA_WIDTH];
        w_sel_ordered = req_is_ordered[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Issue path. The full check uses the registered count only, so a pop in
  // the same cycle never opens issue and there is no ready->valid loop.
  // reset_n gates the combinational outputs so they read 0 during reset.
  // -------------------------------------------------------------------------
  assign w_can_issue = (r_count != CNT_W'(MAX_OUTSTANDING)) &&
                       (r_fence_state == FS_OPEN);

  assign svc_req_valid      = reset_n && w_can_issue && w_any_valid;
  assign svc_req_addr       = w_sel_addr;
  assign svc_req_is_ordered = w_sel_ordered;
  assign w_issue            = svc_req_valid && svc_req_ready;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        req_ready[i] = svc_req_valid && svc_req_ready;
      end
    end
  end

  assign w_prio_next = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

  // -------------------------------------------------------------------------
  // Response path: the tag FIFO head is read straight from flops so routing
  // is zero-latency.
  // -------------------------------------------------------------------------
  assign w_head = r_tag_mem[r_rd_ptr];
  assign w_pop  = svc_rsp_valid && (r_count != '0);

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_head == ID_W'(i)) begin
        rsp_valid[i] = w_pop;
      end
    end
  end

  assign rsp_addr           = svc_rsp_addr;
  assign rsp_error          = svc_rsp_error;
  assign outstanding        = r_count;
  assign err_unexpected_rsp = r_err_unexp;

  // -------------------------------------------------------------------------
  // Fence state machine. No issue is possible while fenced, so the fence tag
  // is always the youngest, and the pop that empties the FIFO is its own.
  // -------------------------------------------------------------------------
  always_comb begin
    w_fence_next = r_fence_state;
    case (r_fence_state)
      FS_OPEN: begin
        if (w_issue && w_sel_ordered) begin
          w_fence_next = FS_FENCE;
        end
      end
      FS_FENCE: begin
        if (w_pop && (r_count == CNT_W'(1))) begin
          w_fence_next = FS_OPEN;
        end
      end
      default: w_fence_next = FS_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fence_state <= FS_OPEN;
    end else begin
      r_fence_state <= w_fence_next;
    end
  end

  // -------------------------------------------------------------------------
  // Priority pointer, FIFO pointers, in-flight count, error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_issue) begin
        r_prio   <= w_prio_next;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (svc_rsp_valid && (r_count == '0)) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_tag_mem[r_wr_ptr] <= w_winner;
    end
  end

endmodule
